// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the multicycle DIV/DIVU unit.
//   DIV_WIDTH   : operand/result width
//   DIV_LATENCY : clock edges from the start edge to the edge that raises ready
//   div_state_e : controller state encoding (IDLE=0 .. DONE=4)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i  : current partial remainder (always < dvs_i)
//   msb_i  : next dividend bit shifted into the remainder
//   dvs_i  : divisor magnitude
//   rem_o  : updated partial remainder
//   qbit_o : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // The trial value needs one extra bit: with unsigned divisors near 2^WIDTH
  // the shifted remainder can exceed WIDTH bits before the subtraction.
  logic [WIDTH:0] trial_s;

  // Shift in the dividend bit, compare against the divisor, restore on miss.
  always_comb begin
    trial_s = {rem_i, msb_i};
    if (trial_s >= {1'b0, dvs_i}) begin
      qbit_o = 1'b1;
      // Result is below dvs_i, so the low WIDTH bits of the difference are exact.
      rem_o  = trial_s[WIDTH-1:0] - dvs_i;
    end else begin
      qbit_o = 1'b0;
      rem_o  = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
// Multicycle signed integer divider for the DIV instruction. One restoring
// step per clock; quotient to lo, remainder to hi, one-cycle ready pulse.
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Optional build macro DIV_UNSIGNED_EN adds the 'unsgn' input (DIVU mode).
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, overrides any operation
//   start    : request, sampled only in IDLE
//   unsgn    : (DIV_UNSIGNED_EN only) unsigned divide, sampled with start
//   a, b     : dividend / divisor (two's complement)
//   hi, lo   : remainder / quotient, registered, updated only at FIX
//   ready    : one-cycle completion pulse
//   div_zero : one-cycle pulse with ready when b was zero
//   busy     : high in every state except IDLE
// -----------------------------------------------------------------------------
import div_pkg::*;

module seq_signed_divider #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             unsgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor (magnitude after PREP)
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_quot_q, sgn_quot_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic             unsgn_q, unsgn_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;

  logic             unsgn_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_qbit_s;

`ifdef DIV_UNSIGNED_EN
  assign unsgn_s = unsgn;
`else
  assign unsgn_s = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .msb_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // Next-state, datapath and output decode for the divide controller.
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    sgn_quot_d = sgn_quot_q;
    sgn_rem_d  = sgn_rem_q;
    unsgn_d    = unsgn_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    ready_d    = 1'b0;
    dz_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == {WIDTH{1'b0}}) begin
            // Divide by zero: report immediately, hi/lo untouched.
            state_d = DONE;
            ready_d = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d    = PREP;
            dvd_d      = a;
            dvs_d      = b;
            unsgn_d    = unsgn_s;
            // Unsigned mode never applies sign correction.
            sgn_quot_d = ~unsgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_rem_d  = ~unsgn_s & a[WIDTH-1];
          end
        end else begin
          state_d = IDLE;
        end
      end

      PREP: begin
        // Magnitudes; -MIN wraps to MIN, which is the correct unsigned value.
        if (!unsgn_q && dvd_q[WIDTH-1]) begin
          dvd_d = -dvd_q;
        end else begin
          dvd_d = dvd_q;
        end
        if (!unsgn_q && dvs_q[WIDTH-1]) begin
          dvs_d = -dvs_q;
        end else begin
          dvs_d = dvs_q;
        end
        rem_d   = {WIDTH{1'b0}};
        quot_d  = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        state_d = ITER;
      end

      ITER: begin
        rem_d  = step_rem_s;
        quot_d = {quot_q[WIDTH-2:0], step_qbit_s};
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end

      FIX: begin
        if (sgn_quot_q) begin
          lo_d = -quot_q;
        end else begin
          lo_d = quot_q;
        end
        if (sgn_rem_q) begin
          hi_d = -rem_q;
        end else begin
          hi_d = rem_q;
        end
        ready_d = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dvd_q      <= {WIDTH{1'b0}};
      dvs_q      <= {WIDTH{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quot_q     <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      sgn_quot_q <= 1'b0;
      sgn_rem_q  <= 1'b0;
      unsgn_q    <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      ready_q    <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      sgn_quot_q <= sgn_quot_d;
      sgn_rem_q  <= sgn_rem_d;
      unsgn_q    <= unsgn_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ready_q    <= ready_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign ready    = ready_q;
  assign div_zero = dz_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_divider
// Self-checking bench: directed cases plus random operands compared against
// a plain-arithmetic model of truncating signed (and optionally unsigned)
// division. Build with +define+DIV_UNSIGNED_EN to exercise the DIVU port.
// -----------------------------------------------------------------------------
module tb_seq_signed_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ready;
  logic        div_zero;
  logic        busy;
  logic        unsgn_tb;

  int n_vec;
  int n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  seq_signed_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef DIV_UNSIGNED_EN
    .unsgn    (unsgn_tb),
`endif
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .ready    (ready),
    .div_zero (div_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: truncating division, remainder follows the dividend sign.
  function automatic void model(input logic [31:0] ai, input logic [31:0] bi,
                                output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    sa = ai;
    sb = bi;
    if (unsgn_tb) begin
      q = ai / bi;
      r = ai % bi;
    end else if (ai == 32'h8000_0000 && bi == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi);
    a     = ai;
    b     = bi;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for ready (bounded), check latency/results, then the IDLE cycle.
  task automatic complete(input string tag, input int lat0, input int exp_lat,
                          input logic dz_exp, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    lat = lat0;
    while (ready !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, dz_exp});
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    @(negedge clk);
    chk({tag, ".ready_drop"}, {31'd0, ready}, 32'd0);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] q;
    logic [31:0] r;
    issue(ai, bi);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    if (bi == 32'd0) begin
      complete(tag, 0, 0, 1'b1, exp_hi, exp_lo);
    end else begin
      model(ai, bi, q, r);
      exp_hi = r;
      exp_lo = q;
      complete(tag, 0, 34, 1'b0, exp_hi, exp_lo);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        saw_ready;
    n_vec    = 0;
    n_err    = 0;
    unsgn_tb = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;

    repeat (3) @(negedge clk);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    chk("reset.ready", {31'd0, ready}, 32'd0);
    chk("reset.div_zero", {31'd0, div_zero}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_div("pos_pos", 32'd100, 32'd7);
    run_div("neg_pos", 32'hFFFF_FF9C, 32'd7);
    run_div("pos_neg", 32'd100, 32'hFFFF_FFF9);
    chk("pos_neg.lo_const", lo, 32'hFFFF_FFF2);
    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("overflow.lo_const", lo, 32'h8000_0000);

    run_div("preload", 32'd100, 32'd7);
    run_div("div0", 32'd5, 32'd0);
    chk("div0.hi_const", hi, 32'd2);
    chk("div0.lo_const", lo, 32'd14);

    // Second start during ITER must be ignored; operands changed afterwards too.
    issue(32'd50, 32'd5);
    repeat (11) @(negedge clk);
    a     = 32'd9;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    exp_hi = 32'd0;
    exp_lo = 32'd10;
    complete("ignored_start", 12, 34, 1'b0, 32'd0, 32'd10);

    // Reset in the middle of an operation discards it.
    issue(32'd123, 32'd4);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset.busy", {31'd0, busy}, 32'd0);
    chk("midreset.ready", {31'd0, ready}, 32'd0);
    chk("midreset.hi", hi, 32'd0);
    chk("midreset.lo", lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    saw_ready = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    chk("midreset.no_ready", {31'd0, saw_ready}, 32'd0);

    // Back-to-back: each run_div ends in the IDLE cycle after ready.
    run_div("b2b_first", 32'd7, 32'd2);
    run_div("b2b_second", 32'hFFFF_FFF9, 32'd2);
    chk("b2b_second.lo_const", lo, 32'hFFFF_FFFD);
    chk("b2b_second.hi_const", hi, 32'hFFFF_FFFF);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 20) - 32'd10;
        1: ra = $urandom_range(0, 1000) - 32'd500;
        2: rb = rb >> $urandom_range(0, 31);
        default: rb = rb;
      endcase
      run_div("random", ra, rb);
    end

`ifdef DIV_UNSIGNED_EN
    unsgn_tb = 1'b1;
    run_div("divu_const", 32'hFFFF_FFFE, 32'd2);
    chk("divu_const.lo_const", lo, 32'h7FFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_div("divu_random", ra, rb);
    end
    unsgn_tb = 1'b0;
    run_div("div_after_divu", 32'hFFFF_FFFE, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multicycle signed 32-bit integer divider serving the DIV instruction (funct 011010).
- Takes operands A and B from the CPU's A/B registers on a start pulse from the control unit and runs one restoring-division step per clock.
- Returns quotient on lo and remainder on hi, feeding the HI/LO registers, with a one-cycle ready pulse.
- Flags divide-by-zero so the control unit can raise the exception.

Parameters:
- WIDTH, 32, operand/result width; the iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  dividend (two's complement)
- b  input  WIDTH  divisor (two's complement)
- hi  output  WIDTH  remainder, registered
- lo  output  WIDTH  quotient, registered
- ready  output  1  one-cycle completion pulse
- div_zero  output  1  one-cycle pulse, coincident with ready, when b==0
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, on the clk edge with reset=1):
  - state=IDLE; hi=0, lo=0, ready=0, div_zero=0, busy=0; counter and internal registers cleared.
  - Reset has priority over everything, including an operation in progress; any pending result is discarded.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE, start=1, b!=0 (sampled at edge t0):
  - Latch a and b; record sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
  - Go to PREP.
- IDLE, start=1, b==0:
  - Go to DONE with the divide-by-zero mark set.
  - ready=1 and div_zero=1 in the cycle after t0; hi/lo keep their previous values.
- IDLE, start=0: stay in IDLE.
- PREP (1 cycle): take absolute values |a| and |b|, clear the partial remainder, counter=0, go to ITER.
- ITER (WIDTH cycles), per cycle:
  - Form rem' = {rem, dividend[MSB]}; shift dividend left by one.
  - If rem' >= |b|: rem = rem' - |b| and shift in quotient bit 1; otherwise rem = rem' and shift in 0.
  - Increment counter; after the WIDTH-th step go to FIX.
- FIX (1 cycle):
  - lo = sign_q ? -quot : quot; hi = sign_r ? -rem : rem.
  - Result truncates toward zero; the remainder takes the sign of the dividend.
  - Go to DONE.
- DONE (1 cycle): ready=1 (plus div_zero=1 if marked); go to IDLE.
- Latency for a normal divide: ready is high in the cycle after edge t0+34 (WIDTH+2 edges after the start edge).
- Overflow case -2^WIDTH-1 / -1: lo=0x80000000, hi=0, by natural wrap; no flag.
- Busy behaviour:
  - start is ignored while busy=1; operands are captured only at the IDLE start edge.
  - A new start may be sampled in the IDLE cycle right after DONE, giving a back-to-back throughput of 36 cycles.
- Output stability: hi and lo change only at the FIX edge or on reset, and hold between operations.

Optional Feature:
- Macro DIV_UNSIGNED_EN.
- When defined:
  - Adds input port unsgn (1 bit), sampled with start.
  - unsgn=1 skips absolute-value and sign correction (DIVU semantics): 0xFFFFFFFE / 2 gives lo=0x7FFFFFFF, hi=0.
  - unsgn=0 is identical to the signed behaviour.
- When undefined: the port does not exist and all divides are signed.

Decomposition:
- Package div_pkg:
  - state encoding constants (IDLE=0, PREP=1, ITER=2, FIX=3, DONE=4, 3-bit);
  - DIV_WIDTH=32;
  - DIV_LATENCY=WIDTH+2.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: new remainder and quotient bit.
  - Instantiated once, inside the ITER datapath.

Test Plan:
- a=100, b=7, start for 1 cycle -> ready exactly 34 edges later; lo=14, hi=2, div_zero=0.
- a=-100 (0xFFFFFF9C), b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); a=100, b=-7 -> lo=-14, hi=2.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, no div_zero.
- Preload hi/lo from a prior op (100/7); then a=5, b=0 -> ready=1 and div_zero=1 in the cycle after start; hi=2, lo=14 unchanged.
- Start 50/5, pulse start again with 9/3 at iteration 10 -> the second start is ignored; result lo=10, hi=0. Then reset at iteration 10 of a new op -> next cycle state IDLE, hi=lo=0, ready=0, busy=0.
- Back-to-back: 7/2 then -7/2 started in the IDLE cycle after ready -> lo=3, hi=1, then lo=-3, hi=-1, each with 34-edge latency.
